// File: rtl/neuron_mac_act.sv
// Sequential neuron with one MAC per clock, a wide non-wrapping accumulator, saturation to N bits and a selectable activation.
// Optional: define NEURON_ROUND_EN to round each product half-up before the >>Q instead of floor truncation.
module neuron_mac_act #(
    parameter int N          = 20,
    parameter int Q          = 18,
    parameter int INPUT_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              act_mode,
    input  logic [INPUT_SIZE*N-1:0] inputs_flat,
    input  logic [INPUT_SIZE*N-1:0] weights_flat,
    input  logic [N-1:0]            bias,
    output logic                    busy,
    output logic                    done,
    output logic [N-1:0]            output_value,
    output logic                    overflow,
    output logic                    tanh_start,
    output logic [N-1:0]            tanh_arg,
    input  logic                    tanh_busy,
    input  logic [N-1:0]            tanh_result
);

    localparam int ACC_W = 2*N - Q + $clog2(INPUT_SIZE + 1) + 1;
    localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic signed [N-1:0]     OUT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0]     OUT_MIN = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N-1:0]     ONE_Q     = {{(N-1){1'b0}}, 1'b1} << Q;
    localparam logic signed [N-1:0]     NEG_ONE_Q = -ONE_Q;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACC       = 3'd1,
        SAT       = 3'd2,
        TANH_HOLD = 3'd3,
        TANH_WAIT = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic [INPUT_SIZE*N-1:0]  inputs_reg, inputs_next;
    logic [INPUT_SIZE*N-1:0]  weights_reg, weights_next;
    logic [1:0]               mode_reg, mode_next;
    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic [IDX_W-1:0]         index_reg, index_next;
    logic                     busy_reg, busy_next;
    logic                     done_reg, done_next;
    logic [N-1:0]             out_reg, out_next;
    logic                     ovf_reg, ovf_next;
    logic                     tstart_reg, tstart_next;
    logic [N-1:0]             targ_reg, targ_next;

    // Operand unpacking so the current pair can be selected by index.
    logic signed [N-1:0] in_arr [INPUT_SIZE];
    logic signed [N-1:0] wt_arr [INPUT_SIZE];

    generate
        for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_unpack
            assign in_arr[gi] = inputs_reg[gi*N +: N];
            assign wt_arr[gi] = weights_reg[gi*N +: N];
        end
    endgenerate

    logic signed [N-1:0]     in_sel, wt_sel;
    logic signed [2*N-1:0]   prod;
    logic signed [2*N-1:0]   prod_adj;
    logic signed [ACC_W-1:0] prod_term;

    assign in_sel = in_arr[index_reg];
    assign wt_sel = wt_arr[index_reg];
    assign prod   = (2*N)'(in_sel) * (2*N)'(wt_sel);

`ifdef NEURON_ROUND_EN
    localparam logic signed [2*N-1:0] ROUND_K = {{(2*N-1){1'b0}}, 1'b1} << (Q - 1);
    assign prod_adj = prod + ROUND_K;
`else
    assign prod_adj = prod;
`endif

    // The shifted product carries only 2N-Q significant bits, so resizing to ACC_W is lossless.
    assign prod_term = ACC_W'(prod_adj >>> Q);

    logic signed [N-1:0] sat_value;
    logic                sat_clip;
    logic signed [N-1:0] act_value;

    always_comb begin
        sat_clip  = 1'b0;
        sat_value = acc_reg[N-1:0];
        if (acc_reg > SAT_MAX) begin
            sat_value = OUT_MAX;
            sat_clip  = 1'b1;
        end else if (acc_reg < SAT_MIN) begin
            sat_value = OUT_MIN;
            sat_clip  = 1'b1;
        end
    end

    always_comb begin
        act_value = sat_value;
        case (mode_reg)
            2'd1: act_value = sat_value[N-1] ? '0 : sat_value;
            2'd3: begin
                if (sat_value > ONE_Q)
                    act_value = ONE_Q;
                else if (sat_value < NEG_ONE_Q)
                    act_value = NEG_ONE_Q;
            end
            default: act_value = sat_value;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (start) state_next = ACC;
            ACC:       if (index_reg == LAST_IDX) state_next = SAT;
            SAT:       state_next = (mode_reg == 2'd2) ? TANH_HOLD : IDLE;
            TANH_HOLD: state_next = TANH_WAIT;
            TANH_WAIT: if (!tanh_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        inputs_next  = inputs_reg;
        weights_next = weights_reg;
        mode_next    = mode_reg;
        acc_next     = acc_reg;
        index_next   = index_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        out_next     = out_reg;
        ovf_next     = ovf_reg;
        tstart_next  = 1'b0;
        targ_next    = targ_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    inputs_next  = inputs_flat;
                    weights_next = weights_flat;
                    mode_next    = act_mode;
                    acc_next     = ACC_W'($signed(bias));
                    index_next   = '0;
                    busy_next    = 1'b1;
                    ovf_next     = 1'b0;
                end
            end
            ACC: begin
                acc_next   = acc_reg + prod_term;
                index_next = index_reg + IDX_W'(1);
            end
            SAT: begin
                ovf_next = sat_clip;
                if (mode_reg == 2'd2) begin
                    targ_next   = sat_value;
                    tstart_next = 1'b1;
                end else begin
                    out_next  = act_value;
                    done_next = 1'b1;
                    busy_next = 1'b0;
                end
            end
            TANH_HOLD: begin
                // tanh_busy may still be low here because the unit has not seen the request yet.
            end
            TANH_WAIT: begin
                if (!tanh_busy) begin
                    out_next  = tanh_result;
                    done_next = 1'b1;
                    busy_next = 1'b0;
                end
            end
            default: busy_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inputs_reg  <= '0;
            weights_reg <= '0;
            mode_reg    <= '0;
            acc_reg     <= '0;
            index_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            out_reg     <= '0;
            ovf_reg     <= 1'b0;
            tstart_reg  <= 1'b0;
            targ_reg    <= '0;
        end else begin
            inputs_reg  <= inputs_next;
            weights_reg <= weights_next;
            mode_reg    <= mode_next;
            acc_reg     <= acc_next;
            index_reg   <= index_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            out_reg     <= out_next;
            ovf_reg     <= ovf_next;
            tstart_reg  <= tstart_next;
            targ_reg    <= targ_next;
        end
    end

    assign busy         = busy_reg;
    assign done         = done_reg;
    assign output_value = out_reg;
    assign overflow     = ovf_reg;
    assign tanh_start   = tstart_reg;
    assign tanh_arg     = targ_reg;

endmodule

// File: doc/neuron_mac_act.md
Name: neuron_mac_act

Overview:
- Parametrised successor to the fixed 20-bit, 4-input neuron.
- Computes one weighted sum with bias, using one MAC per clock and a lossless wide accumulator.
- Saturates the sum to N bits, then applies a run-time selectable activation: identity, ReLU, hard-tanh, or an external CORDIC tanh reached through a start/busy handshake.
- Sits inside layer controllers; several instances share the layer's operand buses.

Parameters:
N, 20, data width of inputs, weights, bias and output (signed fixed point).
Q, 18, fractional bits; 1.0 = 2^Q.
INPUT_SIZE, 4, number of input/weight pairs (>=1).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
act_mode  in  2  0 identity, 1 ReLU, 2 tanh (external), 3 hard-tanh clamp to ±1.0.
inputs_flat  in  INPUT_SIZE*N  input i at bits [i*N +: N], signed.
weights_flat  in  INPUT_SIZE*N  weight i at bits [i*N +: N], signed.
bias  in  N  signed bias, Q format.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse when output_value updates.
output_value  out  N  registered result.
overflow  out  1  set when saturation clipped the sum; valid with done, held until next accept.
tanh_start  out  1  one-cycle request to the tanh unit.
tanh_arg  out  N  saturated sum presented to the tanh unit; held stable while in TANH states.
tanh_busy  in  1  tanh unit busy.
tanh_result  in  N  tanh unit result, valid when tanh_busy is low after a request.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, overflow, tanh_start=0; output_value, tanh_arg, accumulator, index=0.
- IDLE, start=1:
  - Latch inputs_flat, weights_flat, bias, act_mode into internal registers.
  - Set acc = sign-extended bias, index=0, busy=1, overflow=0 → ACC.
  - Operand buses may change freely after the accept edge.
- ACC: one product per cycle.
  - Product: full 2N-bit signed product, arithmetic shift right by Q (floor).
  - Accumulate into ACC_W = 2N-Q+clog2(INPUT_SIZE+1)+1 bits; the accumulator never wraps.
  - After index==INPUT_SIZE-1 is accumulated → SAT. ACC lasts exactly INPUT_SIZE cycles.
- SAT: clamp acc to [-2^(N-1), 2^(N-1)-1]; overflow=1 if clamped. Then, by act_mode:
  - Mode 0: output = sat.
  - Mode 1: output = sat<0 ? 0 : sat.
  - Mode 3: clamp sat to [-2^Q, 2^Q].
  - Modes 0, 1, 3: write output_value, done=1, busy=0 → IDLE.
  - Mode 2: tanh_arg=sat, tanh_start=1 → TANH_HOLD.
- TANH_HOLD: tanh_start=0; tanh_busy is ignored this cycle → TANH_WAIT.
- TANH_WAIT: when tanh_busy==0, output_value=tanh_result, done=1, busy=0 → IDLE. There is no timeout.
- Latency, counted in rising edges after the start-accept edge:
  - Modes 0, 1, 3: done is high in the cycle after edge INPUT_SIZE+1.
  - Mode 2: done is high one cycle after tanh_busy is sampled low in TANH_WAIT.
- done is a single-cycle pulse. start is ignored while busy, including start held high. Back-to-back: start asserted in the done cycle is accepted.
- Unused/illegal states → IDLE.

Optional Feature:
NEURON_ROUND_EN:
- Defined: each product has 2^(Q-1) added before the >>Q, giving round-half-up.
- Undefined: plain floor truncation.
- All other behaviour, including saturation and latency, is identical.

Test Plan:
- N=20, Q=18, all inputs 131072 (0.5), all weights 131072, bias 0, mode 0 → output_value=262144, overflow=0, done in the cycle after edge 5.
- Same operands, weights -131072, bias 0, mode 1 → output_value=0 (sum -262144), overflow=0.
- Inputs 393216, weights 393216 (sum 9.0), mode 0 → output_value=524287, overflow=1. With weights -393216 → output_value=-524288, overflow=1.
- Mode 2 with sum 262144; stub raises tanh_busy 1 cycle after tanh_start, holds it 10 cycles, returns 199651:
  - tanh_start high for exactly 1 cycle with tanh_arg=262144.
  - output_value=199651, with done the cycle after tanh_busy falls.
- Mode 3 with sum 393216 → output 262144. Start pulsed while busy → no restart. Reset asserted mid-ACC → busy=0, output_value=0, state IDLE.
- Input 1 and -1 (LSB), weight 131072, bias 0, mode 0, INPUT_SIZE=1:
  - NEURON_ROUND_EN undefined: outputs 0 and -1.
  - NEURON_ROUND_EN defined: outputs 1 and 0.
